nncell_seq_mac: RTL and testbench

Sequential FP32 neuron cell. It holds a programmable weight vector and a bias. It streams in up to MAX_INPUTS activations over a valid/ready handshake and accumulates x[i]·w[i] (add or subtract), then adds the bias. It applies an optional ReLU and presents one result on a valid/ready output port. It is the multi-input, self-sequencing successor of the single-term accumulate cell and sits between the activation cache bus and the next layer's input FIFO.

---
 rtl/nncell_seq_mac.sv | 332 +++++++++++++++++++++++++++++++++
 tb/tb_nncell_seq_mac.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nncell_seq_mac.sv
// ============================================================================
//  Module   : nncell_seq_mac (with nncell_fp32_mul, nncell_fp32_addsub)
//  Brief    : Sequential FP32 neuron cell: streamed x[i]*w[i] accumulate,
//             bias add, optional ReLU, valid/ready in and out.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

// Combinational FP32 multiplier, round-to-nearest-even, denormals flushed to zero.
module nncell_fp32_mul (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic              sign;
    logic [7:0]        ea, eb;
    logic [22:0]       fa, fb;
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [47:0]       prod;
    logic signed [9:0] e_sum, e_res;
    logic [23:0]       mant;
    logic              guard, sticky, rnd;
    logic [24:0]       mant_r;
    logic [22:0]       frac;

    always_comb begin
        sign   = a[31] ^ b[31];
        ea     = a[30:23];
        eb     = b[30:23];
        fa     = a[22:0];
        fb     = b[22:0];
        a_zero = (ea == 8'd0);
        b_zero = (eb == 8'd0);
        a_inf  = (ea == 8'hFF) && (fa == 23'd0);
        b_inf  = (eb == 8'hFF) && (fb == 23'd0);
        a_nan  = (ea == 8'hFF) && (fa != 23'd0);
        b_nan  = (eb == 8'hFF) && (fb != 23'd0);

        prod   = {1'b1, fa} * {1'b1, fb};
        e_sum  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;

        if (prod[47]) begin
            mant   = prod[47:24];
            guard  = prod[23];
            sticky = |prod[22:0];
            e_res  = e_sum + 10'sd1;
        end else begin
            mant   = prod[46:23];
            guard  = prod[22];
            sticky = |prod[21:0];
            e_res  = e_sum;
        end

        rnd    = guard & (sticky | mant[0]);
        mant_r = {1'b0, mant} + {24'd0, rnd};
        if (mant_r[24]) begin
            frac  = mant_r[23:1];
            e_res = e_res + 10'sd1;
        end else begin
            frac  = mant_r[22:0];
        end

        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            y = QNAN;
        else if (a_inf || b_inf)
            y = {sign, 8'hFF, 23'd0};
        else if (a_zero || b_zero)
            y = {sign, 31'd0};
        else if (e_res >= 10'sd255)
            y = {sign, 8'hFF, 23'd0};
        else if (e_res <= 10'sd0)
            y = {sign, 31'd0};
        else
            y = {sign, e_res[7:0], frac};
    end
endmodule

// Combinational FP32 adder/subtractor (y = a + b or a - b), round-to-nearest-even.
module nncell_fp32_addsub (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic [31:0] y
);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic              sa, sb, eff_sub, swap, s_res;
    logic [7:0]        ea, eb, e_big, e_sml, diff;
    logic [22:0]       fa, fb;
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [26:0]       m_big, m_sml, m_al, mask, norm;
    logic              sticky, rnd;
    logic [27:0]       sum;
    logic [4:0]        lz;
    logic signed [9:0] e_res;
    logic [24:0]       mant_r;
    logic [22:0]       frac;

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        lzc27 = 5'd27;
        for (int i = 0; i < 27; i++)
            if (v[i]) lzc27 = 5'(26 - i);
    endfunction

    always_comb begin
        sa      = a[31];
        sb      = b[31] ^ sub;
        ea      = a[30:23];
        eb      = b[30:23];
        fa      = a[22:0];
        fb      = b[22:0];
        a_zero  = (ea == 8'd0);
        b_zero  = (eb == 8'd0);
        a_inf   = (ea == 8'hFF) && (fa == 23'd0);
        b_inf   = (eb == 8'hFF) && (fb == 23'd0);
        a_nan   = (ea == 8'hFF) && (fa != 23'd0);
        b_nan   = (eb == 8'hFF) && (fb != 23'd0);
        eff_sub = sa ^ sb;

        // Larger magnitude goes first so the difference is never negative.
        swap    = (b[30:0] > a[30:0]);
        e_big   = swap ? eb : ea;
        e_sml   = swap ? ea : eb;
        m_big   = {1'b1, (swap ? fb : fa), 3'b000};
        m_sml   = {1'b1, (swap ? fa : fb), 3'b000};
        s_res   = swap ? sb : sa;
        diff    = e_big - e_sml;

        mask    = '0;
        if (diff > 8'd26) begin
            m_al   = 27'd0;
            sticky = 1'b1;
        end else begin
            mask   = ~(27'h7FF_FFFF << diff);
            m_al   = m_sml >> diff;
            sticky = |(m_sml & mask);
        end
        m_al[0] = m_al[0] | sticky;

        sum = eff_sub ? ({1'b0, m_big} - {1'b0, m_al}) : ({1'b0, m_big} + {1'b0, m_al});
        lz  = lzc27(sum[26:0]);
        if (sum[27]) begin
            norm  = {sum[27:2], sum[1] | sum[0]};
            e_res = $signed({2'b00, e_big}) + 10'sd1;
        end else begin
            norm  = sum[26:0] << lz;
            e_res = $signed({2'b00, e_big}) - $signed({5'b00000, lz});
        end

        rnd    = norm[2] & (norm[1] | norm[0] | norm[3]);
        mant_r = {1'b0, norm[26:3]} + {24'd0, rnd};
        if (mant_r[24]) begin
            frac  = mant_r[23:1];
            e_res = e_res + 10'sd1;
        end else begin
            frac  = mant_r[22:0];
        end

        if (a_nan || b_nan || (a_inf && b_inf && eff_sub))
            y = QNAN;
        else if (a_inf)
            y = {sa, 8'hFF, 23'd0};
        else if (b_inf)
            y = {sb, 8'hFF, 23'd0};
        else if (a_zero && b_zero)
            y = {sa & sb, 31'd0};
        else if (b_zero)
            y = a;
        else if (a_zero)
            y = {sb, b[30:0]};
        else if (sum == 28'd0)
            y = 32'd0;
        else if (e_res >= 10'sd255)
            y = {s_res, 8'hFF, 23'd0};
        else if (e_res <= 10'sd0)
            y = {s_res, 31'd0};
        else
            y = {s_res, e_res[7:0], frac};
    end
endmodule

module nncell_seq_mac #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_INPUTS = 16,
    parameter int ADDR_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_W:0]       cfg_len,
    input  logic                  cfg_sub,
    input  logic                  cfg_relu,
    input  logic                  w_we,
    input  logic [ADDR_W-1:0]     w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  bias_we,
    input  logic [DATA_WIDTH-1:0] bias_data,
    input  logic                  x_valid,
    output logic                  x_ready,
    input  logic [DATA_WIDTH-1:0] x_data,
    output logic                  y_valid,
    input  logic                  y_ready,
    output logic [DATA_WIDTH-1:0] y_data,
    output logic                  busy
);
    localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(MAX_INPUTS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACC   = 3'd1,
        S_DRAIN = 3'd2,
        S_BIAS  = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    state_t                state, state_nx;
    logic [DATA_WIDTH-1:0] weights [MAX_INPUTS];
    logic [DATA_WIDTH-1:0] bias, x_r, w_r, acc, prod, sum, add_b;
    logic [ADDR_W-1:0]     idx;
    logic [ADDR_W:0]       len_eff, last_new, last_q, cur_last;
    logic                  sub_q, relu_q, pend, pend_first;
    logic                  take, is_last, add_sub;

    // Config for term 0 comes straight from the ports; later terms use the latched copy.
    always_comb begin
        len_eff = cfg_len;
        if (cfg_len == '0)
            len_eff = (ADDR_W+1)'(1);
        else if (cfg_len > MAX_LEN)
            len_eff = MAX_LEN;
        last_new = len_eff - (ADDR_W+1)'(1);
        cur_last = (state == S_IDLE) ? last_new : last_q;
    end

    assign take    = x_valid && ((state == S_IDLE) || (state == S_ACC));
    assign is_last = ({1'b0, idx} == cur_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        x_ready  = 1'b0;
        busy     = 1'b1;
        case (state)
            S_IDLE: begin
                x_ready = 1'b1;
                busy    = 1'b0;
                if (take) state_nx = is_last ? S_DRAIN : S_ACC;
            end
            S_ACC: begin
                x_ready = 1'b1;
                if (take && is_last) state_nx = S_DRAIN;
            end
            S_DRAIN: state_nx = S_BIAS;
            S_BIAS:  state_nx = S_OUT;
            S_OUT:   if (y_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // One adder serves both the accumulate step and the final bias add; they never overlap.
    assign add_b   = (state == S_BIAS) ? bias : prod;
    assign add_sub = (state == S_BIAS) ? 1'b0 : sub_q;

    nncell_fp32_mul u_mul (
        .a (x_r),
        .b (w_r),
        .y (prod)
    );

    nncell_fp32_addsub u_add (
        .a   (acc),
        .b   (add_b),
        .sub (add_sub),
        .y   (sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_INPUTS; i++)
                weights[i] <= '0;
            bias       <= '0;
            x_r        <= '0;
            w_r        <= '0;
            acc        <= '0;
            y_data     <= '0;
            y_valid    <= 1'b0;
            idx        <= '0;
            last_q     <= '0;
            sub_q      <= 1'b0;
            relu_q     <= 1'b0;
            pend       <= 1'b0;
            pend_first <= 1'b0;
        end else begin
            if (w_we && ({1'b0, w_addr} < MAX_LEN))
                weights[w_addr] <= w_data;
            if (bias_we)
                bias <= bias_data;

            pend <= take;
            if (take) begin
                x_r        <= x_data;
                w_r        <= weights[idx];
                pend_first <= (state == S_IDLE);
                idx        <= is_last ? '0 : idx + ADDR_W'(1);
                if (state == S_IDLE) begin
                    last_q <= last_new;
                    sub_q  <= cfg_sub;
                    relu_q <= cfg_relu;
                end
            end

            if (pend)
                acc <= pend_first ? {prod[31] ^ sub_q, prod[30:0]} : sum;

            if (state == S_BIAS) begin
                y_data  <= (relu_q && sum[31]) ? '0 : sum;
                y_valid <= 1'b1;
            end else if ((state == S_OUT) && y_ready) begin
                y_valid <= 1'b0;
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_nncell_seq_mac.sv
// ============================================================================
//  Module   : tb_nncell_seq_mac
//  Brief    : Directed scoreboard bench for nncell_seq_mac.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nncell_seq_mac;
    localparam logic [31:0] F_1   = 32'h3F80_0000;
    localparam logic [31:0] F_2   = 32'h4000_0000;
    localparam logic [31:0] F_3   = 32'h4040_0000;
    localparam logic [31:0] F_4   = 32'h4080_0000;
    localparam logic [31:0] F_H   = 32'h3F00_0000;
    localparam logic [31:0] F_9P5 = 32'h4118_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  cfg_len;
    logic        cfg_sub, cfg_relu;
    logic        w_we;
    logic [3:0]  w_addr;
    logic [31:0] w_data;
    logic        bias_we;
    logic [31:0] bias_data;
    logic        x_valid, x_ready;
    logic [31:0] x_data;
    logic        y_valid, y_ready;
    logic [31:0] y_data;
    logic        busy;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;

    nncell_seq_mac #(.DATA_WIDTH(32), .MAX_INPUTS(16), .ADDR_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_len   (cfg_len),
        .cfg_sub   (cfg_sub),
        .cfg_relu  (cfg_relu),
        .w_we      (w_we),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .bias_we   (bias_we),
        .bias_data (bias_data),
        .x_valid   (x_valid),
        .x_ready   (x_ready),
        .x_data    (x_data),
        .y_valid   (y_valid),
        .y_ready   (y_ready),
        .y_data    (y_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Monitor: every output handshake is scored against the next queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && y_valid && y_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL y_unexpected: got %h with nothing expected", y_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (y_data !== mon_exp) begin
                        n_err++;
                        $display("FAIL y_data: got %h, expected %h", y_data, mon_exp);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    task automatic wr_w(input logic [3:0] a, input logic [31:0] d);
        w_we = 1'b1; w_addr = a; w_data = d;
        step();
        w_we = 1'b0;
    endtask

    task automatic wr_bias(input logic [31:0] d);
        bias_we = 1'b1; bias_data = d;
        step();
        bias_we = 1'b0;
    endtask

    task automatic send_term(input logic [31:0] d, input int gap);
        int budget;
        x_valid = 1'b0;
        repeat (gap) step();
        x_valid = 1'b1;
        x_data  = d;
        budget  = 64;
        while (!x_ready && budget > 0) begin
            step();
            budget--;
        end
        if (!x_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL x_ready_timeout: x_ready %b, expected 1", x_ready);
        end
        step();
        x_valid = 1'b0;
    endtask

    task automatic send3(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input int gap);
        send_term(a, gap);
        send_term(b, gap);
        send_term(c, gap);
    endtask

    task automatic wait_idle();
        int budget = 64;
        while ((exp_q.size() != 0 || y_valid) && budget > 0) begin
            step();
            budget--;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL result_timeout: %0d results outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        rst_n = 1'b0; cfg_len = 5'd3; cfg_sub = 1'b0; cfg_relu = 1'b0;
        w_we = 1'b0; w_addr = '0; w_data = '0; bias_we = 1'b0; bias_data = '0;
        x_valid = 1'b0; x_data = '0; y_ready = 1'b0;
        repeat (3) step();
        check("rst_y_valid", {31'd0, y_valid}, 32'd0);
        check("rst_busy",    {31'd0, busy},    32'd0);
        check("rst_y_data",  y_data,           32'd0);
        rst_n = 1'b1;
        step();
        check("rst_x_ready", {31'd0, x_ready}, 32'd1);

        wr_w(4'd0, F_1); wr_w(4'd1, F_2); wr_w(4'd2, F_3); wr_bias(F_H);

        // 1*1 + 1*2 + 2*3 + 0.5 = 9.5, with latency and held backpressure
        exp_q.push_back(F_9P5);
        send3(F_1, F_1, F_2, 0);
        check("lat_x_ready_k", {31'd0, x_ready}, 32'd0);
        check("lat_y_valid_k", {31'd0, y_valid}, 32'd0);
        step();
        check("lat_y_valid_k1", {31'd0, y_valid}, 32'd0);
        step();
        check("lat_y_valid_k2", {31'd0, y_valid}, 32'd1);
        check("lat_y_data_k2",  y_data, F_9P5);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_y_valid", {31'd0, y_valid}, 32'd1);
            check("bp_y_data",  y_data, F_9P5);
            check("bp_x_ready", {31'd0, x_ready}, 32'd0);
        end
        y_ready = 1'b1;
        step();
        check("post_hs_y_valid", {31'd0, y_valid}, 32'd0);
        check("post_hs_x_ready", {31'd0, x_ready}, 32'd1);

        // Subtract (-8.5) then subtract with ReLU (0), second starting right after the handshake
        cfg_sub = 1'b1;
        exp_q.push_back(32'hC108_0000);
        send3(F_1, F_1, F_2, 0);
        cfg_relu = 1'b1;
        exp_q.push_back(32'h0000_0000);
        send3(F_1, F_1, F_2, 0);
        wait_idle();
        cfg_sub = 1'b0; cfg_relu = 1'b0;

        // Bubbles between terms leave the result unchanged
        exp_q.push_back(F_9P5);
        send3(F_1, F_1, F_2, 2);
        wait_idle();

        // w[2] written on the edge that accepts term 2: old weight for this vector, new for next
        exp_q.push_back(F_9P5);
        send_term(F_1, 0);
        send_term(F_1, 0);
        w_we = 1'b1; w_addr = 4'd2; w_data = F_4;
        send_term(F_2, 0);
        w_we = 1'b0;
        wait_idle();
        exp_q.push_back(32'h4138_0000);     // 1 + 2 + 2*4 + 0.5 = 11.5
        send3(F_1, F_1, F_2, 0);
        wait_idle();
        wr_w(4'd2, F_3);

        // len=1 with negative weight: 2 * -1.5 + 0 = -3
        wr_w(4'd0, 32'hBFC0_0000); wr_bias(32'd0);
        cfg_len = 5'd1;
        y_ready = 1'b0;
        exp_q.push_back(32'hC040_0000);
        send_term(F_2, 0);
        check("len1_drain_x_ready", {31'd0, x_ready}, 32'd0);
        check("len1_drain_busy",    {31'd0, busy},    32'd1);
        step();
        check("len1_bias_y_valid",  {31'd0, y_valid}, 32'd0);
        step();
        check("len1_out_y_valid",   {31'd0, y_valid}, 32'd1);
        y_ready = 1'b1;
        wait_idle();
        wr_w(4'd0, F_1); wr_bias(F_H);

        // len=0 behaves as len=1: 2*1 + 0.5 = 2.5
        cfg_len = 5'd0;
        exp_q.push_back(32'h4020_0000);
        send_term(F_2, 0);
        wait_idle();

        // Reset mid-vector clears weights and bias
        cfg_len = 5'd3;
        send_term(F_1, 0);
        send_term(F_1, 0);
        rst_n = 1'b0;
        #1;
        check("midrst_y_valid", {31'd0, y_valid}, 32'd0);
        check("midrst_busy",    {31'd0, busy},    32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("midrst_x_ready", {31'd0, x_ready}, 32'd1);
        exp_q.push_back(32'h0000_0000);
        send3(F_1, F_1, F_2, 0);
        wait_idle();
        wr_w(4'd0, F_1); wr_w(4'd1, F_2); wr_w(4'd2, F_3); wr_bias(F_H);
        exp_q.push_back(F_9P5);
        send3(F_1, F_1, F_2, 0);
        wait_idle();

        // len above 16 clamps to 16 terms; w[3..15] are zero: 1+2+3+0.5 = 6.5
        cfg_len = 5'd31;
        exp_q.push_back(32'h40D0_0000);
        for (int i = 0; i < 16; i++) send_term(F_1, 0);
        check("clamp_x_ready", {31'd0, x_ready}, 32'd0);
        wait_idle();

        check("queue_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

`default_nettype wire
